// File: rtl/segment_collision_checker.sv
`default_nettype none
// ============================================================================
// Module   : segment_collision_checker
// Purpose  : Bresenham walk from start to end cell, querying the occupancy
//            grid one cell at a time; stops at the first occupied cell.
// Revision : 1.0  initial release
// ============================================================================
module segment_collision_checker #(
    parameter int GRID_WIDTH_LOG2  = 8,
    parameter int GRID_HEIGHT_LOG2 = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [GRID_WIDTH_LOG2-1:0]  start_x,
    input  logic [GRID_HEIGHT_LOG2-1:0] start_y,
    input  logic [GRID_WIDTH_LOG2-1:0]  end_x,
    input  logic [GRID_HEIGHT_LOG2-1:0] end_y,
    input  logic                        req_valid,
    output logic                        req_ready,
    output logic                        result_valid,
    input  logic                        result_ready,
    output logic                        collision,
    output logic [((GRID_WIDTH_LOG2 > GRID_HEIGHT_LOG2) ? GRID_WIDTH_LOG2 : GRID_HEIGHT_LOG2):0] cells_checked,
    output logic [GRID_WIDTH_LOG2-1:0]  grid_cell_x,
    output logic [GRID_HEIGHT_LOG2-1:0] grid_cell_y,
    output logic                        grid_input_valid,
    input  logic                        grid_ready_for_input,
    input  logic                        grid_output_valid,
    input  logic                        grid_read_occupied,
    output logic                        grid_write_enable,
    output logic                        grid_write_occupied
);

    localparam int MAXW = (GRID_WIDTH_LOG2 > GRID_HEIGHT_LOG2) ? GRID_WIDTH_LOG2 : GRID_HEIGHT_LOG2;
    localparam int ERRW = MAXW + 2;

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_issue = 2'd1;
    localparam logic [1:0] c_wait  = 2'd2;
    localparam logic [1:0] c_done  = 2'd3;

    localparam logic [GRID_WIDTH_LOG2-1:0]  c_one_x   = 1;
    localparam logic [GRID_HEIGHT_LOG2-1:0] c_one_y   = 1;
    localparam logic [MAXW:0]               c_one_cnt = 1;
    localparam logic signed [ERRW-1:0]      c_zero_e  = '0;

    logic [1:0]                  r_state;
    logic [1:0]                  w_state_next;
    logic [GRID_WIDTH_LOG2-1:0]  r_cur_x;
    logic [GRID_HEIGHT_LOG2-1:0] r_cur_y;
    logic [GRID_WIDTH_LOG2-1:0]  r_end_x;
    logic [GRID_HEIGHT_LOG2-1:0] r_end_y;
    logic signed [ERRW-1:0]      r_dx;
    logic signed [ERRW-1:0]      r_dy;
    logic signed [ERRW-1:0]      r_err;
    logic                        r_sx_neg;
    logic                        r_sy_neg;
    logic [MAXW:0]               r_count;
    logic                        r_collision;

    logic signed [ERRW-1:0]      w_dx;
    logic signed [ERRW-1:0]      w_dy_abs;
    logic signed [ERRW-1:0]      w_dy;
    logic signed [ERRW-1:0]      w_e2;
    logic signed [ERRW-1:0]      w_err_next;
    logic                        w_step_x;
    logic                        w_step_y;
    logic                        w_at_end;

    assign w_dx = (end_x >= start_x) ? (ERRW'(end_x) - ERRW'(start_x))
                                     : (ERRW'(start_x) - ERRW'(end_x));
    assign w_dy_abs = (end_y >= start_y) ? (ERRW'(end_y) - ERRW'(start_y))
                                         : (ERRW'(start_y) - ERRW'(end_y));
    assign w_dy = c_zero_e - w_dy_abs;

    // Both axis decisions use the pre-step error term.
    assign w_e2       = {r_err[ERRW-2:0], 1'b0};
    assign w_step_x   = (w_e2 >= r_dy);
    assign w_step_y   = (w_e2 <= r_dx);
    assign w_err_next = r_err + (w_step_x ? r_dy : c_zero_e) + (w_step_y ? r_dx : c_zero_e);
    assign w_at_end   = (r_cur_x == r_end_x) && (r_cur_y == r_end_y);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        req_ready        = 1'b0;
        result_valid     = 1'b0;
        grid_input_valid = 1'b0;
        case (r_state)
            c_idle: begin
                req_ready = 1'b1;
                if (req_valid) w_state_next = c_issue;
            end
            c_issue: begin
                grid_input_valid = 1'b1;
                if (grid_ready_for_input) w_state_next = c_wait;
            end
            c_wait: begin
                if (grid_output_valid) begin
                    w_state_next = (grid_read_occupied || w_at_end) ? c_done : c_issue;
                end
            end
            c_done: begin
                result_valid = 1'b1;
                if (result_ready) w_state_next = c_idle;
            end
            default: w_state_next = c_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur_x     <= '0;
            r_cur_y     <= '0;
            r_end_x     <= '0;
            r_end_y     <= '0;
            r_dx        <= '0;
            r_dy        <= '0;
            r_err       <= '0;
            r_sx_neg    <= 1'b0;
            r_sy_neg    <= 1'b0;
            r_count     <= '0;
            r_collision <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (req_valid) begin
                        r_cur_x     <= start_x;
                        r_cur_y     <= start_y;
                        r_end_x     <= end_x;
                        r_end_y     <= end_y;
                        r_dx        <= w_dx;
                        r_dy        <= w_dy;
                        r_err       <= w_dx + w_dy;
                        r_sx_neg    <= (end_x < start_x);
                        r_sy_neg    <= (end_y < start_y);
                        r_count     <= '0;
                        r_collision <= 1'b0;
                    end
                end
                c_issue: begin
                    if (grid_ready_for_input) r_count <= r_count + c_one_cnt;
                end
                c_wait: begin
                    if (grid_output_valid) begin
                        if (grid_read_occupied) begin
                            r_collision <= 1'b1;
                        end else if (!w_at_end) begin
                            r_err <= w_err_next;
                            if (w_step_x) r_cur_x <= r_sx_neg ? (r_cur_x - c_one_x) : (r_cur_x + c_one_x);
                            if (w_step_y) r_cur_y <= r_sy_neg ? (r_cur_y - c_one_y) : (r_cur_y + c_one_y);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign collision           = r_collision;
    assign cells_checked       = r_count;
    assign grid_cell_x         = r_cur_x;
    assign grid_cell_y         = r_cur_y;
    assign grid_write_enable   = 1'b0;
    assign grid_write_occupied = 1'b0;

endmodule
`default_nettype wire

// File: doc/segment_collision_checker.md
# segment_collision_checker

Rasterizes a straight grid segment between two cells and queries the occupancy grid cell by cell. It reports whether any cell on the segment is occupied. It is the initiator on the occupancy grid's cell-query handshake and sits between the RRT extend/steer logic and the `occupancy_grid` instance. The checker issues reads only, one outstanding query at a time, and terminates early on the first occupied cell.

## Interface

- `GRID_WIDTH_LOG2`, 8, bits of x coordinate; must match the occupancy grid.
- `GRID_HEIGHT_LOG2`, 8, bits of y coordinate; must match the occupancy grid.
- Derived `MAXW` = max(`GRID_WIDTH_LOG2`, `GRID_HEIGHT_LOG2`); `ERRW` = `MAXW`+2 (signed error term).

Ports:

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start_x`  in  `GRID_WIDTH_LOG2`  segment start cell x.
- `start_y`  in  `GRID_HEIGHT_LOG2`  segment start cell y.
- `end_x`  in  `GRID_WIDTH_LOG2`  segment end cell x.
- `end_y`  in  `GRID_HEIGHT_LOG2`  segment end cell y.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  checker idle, accepts request.
- `result_valid`  out  1  result available.
- `result_ready`  in  1  consumer takes result.
- `collision`  out  1  1 = an occupied cell was found.
- `cells_checked`  out  `MAXW`+1  number of cells queried, including the occupied one.
- `grid_cell_x`  out  `GRID_WIDTH_LOG2`  query x, to occupancy grid `cell_x`.
- `grid_cell_y`  out  `GRID_HEIGHT_LOG2`  query y, to occupancy grid `cell_y`.
- `grid_input_valid`  out  1  query valid.
- `grid_ready_for_input`  in  1  grid accepts query.
- `grid_output_valid`  in  1  grid response valid.
- `grid_read_occupied`  in  1  response data.
- `grid_write_enable`  out  1  constant 0.
- `grid_write_occupied`  out  1  constant 0.

## Operation

States:

- IDLE: `req_ready`=1. On `req_valid`:
  - latch endpoints;
  - set cur=(start_x,start_y), dx=|ex-sx|, dy=-|ey-sy|, sx/sy=±1 step signs, err=dx+dy, count=0;
  - go to ISSUE.
- ISSUE: `grid_input_valid`=1, `grid_cell_x/y`=cur. Address is held stable while `grid_ready_for_input`=0. On `grid_ready_for_input`=1: count++, go to WAIT.
- WAIT: `grid_input_valid`=0. `grid_output_valid` is sampled only in this state.
  - Response occupied=1: `collision`←1, go to DONE.
  - Response occupied=0 and cur==end: `collision`←0, go to DONE.
  - Otherwise, in the same cycle, apply a Bresenham step with e2=2·err in `ERRW`-bit signed arithmetic:
    - if e2≥dy: err+=dy, x+=sx;
    - if e2≤dx: err+=dx, y+=sy;
    - both updates use the pre-step err and apply in the same cycle. Then go to ISSUE.
- DONE: `result_valid`=1; `collision` and `cells_checked` are held. On `result_ready`=1, go to IDLE.

Boundary conditions:

- Both endpoints are always checked.
- start==end: exactly one query.
- Coordinates never leave the bounding box of the endpoints, so no wrap-around occurs.
- Endpoint inputs are ignored after acceptance; changing them mid-operation has no effect.
- `cells_checked` maximum is 2^`MAXW`; the width is sufficient.

## Timing

- While `rst`=1 and immediately after reset:
  - state IDLE;
  - `req_ready`=1;
  - `result_valid`, `grid_input_valid`, `collision`, `cells_checked`, `grid_cell_x`, `grid_cell_y` = 0.
- `req_ready` is 1 exactly in IDLE.
- A request accepted at edge N puts the first query on the grid during cycle N+1.
- Per cell: 1 ISSUE cycle (more if stalled) + grid latency L. The next query is issued in the cycle after the response.
- `result_valid` rises the cycle after the final response and stays high until `result_ready`. The next request can be accepted one cycle after DONE exits.
- Reset mid-operation aborts immediately to the reset values. The occupancy grid shares the same reset, so no stale response reaches a later WAIT.
- `grid_write_enable` = `grid_write_occupied` = 0 in every state.

## Test plan

- Empty grid, (0,0)→(3,1) → queries (0,0),(1,0),(2,1),(3,1) in order; `collision`=0, `cells_checked`=4.
- Same segment with (2,1) occupied → queries stop after (2,1) and (3,1) is never issued; `collision`=1, `cells_checked`=3.
- Reverse, steep segment (1,4)→(1,0), empty grid → queries (1,4),(1,3),(1,2),(1,1),(1,0); `collision`=0, `cells_checked`=5.
- start=end=(5,5) with (5,5) occupied → one query; `collision`=1, `cells_checked`=1.
- `grid_ready_for_input` held low for 3 cycles on the second cell → `grid_input_valid` stays 1 with the coordinates unchanged for those cycles; final result identical to the unstalled run.
- `result_ready` held low for 4 cycles → `result_valid`, `collision` and `cells_checked` are stable and `req_ready`=0 throughout.
- `rst` pulsed while in WAIT → all outputs go to reset values in the same cycle; a following (0,0)→(3,1) request completes correctly.
